// File: rtl/pipe_stage_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage register.
// Used by pipe_stage_skid_reg and skid_data_reg.
package pipe_stage_pkg;

    localparam int OCC_W = 2;
    localparam logic [OCC_W-1:0] FULL_ENC = 2'd2;

    // The encoding doubles as the occupancy count, so no decode is needed.
    typedef enum logic [OCC_W-1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = FULL_ENC
    } stage_state_t;

    function automatic logic [OCC_W-1:0] state_to_occ(input stage_state_t s);
        return OCC_W'(s);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_data.sv
// WIDTH-bit load-enable data register with asynchronous reset to a parameter value.
// Holds either the main or the skid entry of pipe_stage_skid_reg.
module skid_data_reg
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with two-entry skid buffer, flush, Tick step-enable and occupancy.
// Define PIPE_SKID_TRISTATE_EN to add the cs port that tristates out_data.
//
// state    | meaning
// ---------+------------------------------------------------
// ST_EMPTY | nothing held, out_data shows last popped value
// ST_ONE   | main entry valid, skid free
// ST_FULL  | main and skid valid, in_ready low
module pipe_stage_skid_reg
    import pipe_stage_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Tick,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef PIPE_SKID_TRISTATE_EN
    output logic [OCC_W-1:0] occupancy,
    input  logic             cs
`else
    output logic [OCC_W-1:0] occupancy
`endif
);

    stage_state_t     state;
    stage_state_t     state_nxt;
    logic             push;
    logic             pop;
    logic             load_main;
    logic             load_skid;
    logic             main_from_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    assign push = in_valid & in_ready & Tick;
    assign pop  = out_valid & out_ready & Tick;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    state_nxt = ST_ONE;
                    load_main = 1'b1;
                end
            end
            ST_ONE: begin
                if (push && !pop) begin
                    state_nxt = ST_FULL;
                    load_skid = 1'b1;
                end else if (push && pop) begin
                    load_main = 1'b1;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_nxt      = ST_ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Flush kills held entries but leaves the data registers as they were.
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state     <= ST_EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != ST_FULL);
            out_valid <= (state_nxt != ST_EMPTY);
        end
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    skid_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .Clock (Clock),
        .Reset (Reset),
        .load  (load_main),
        .d     (main_d),
        .q     (main_q)
    );

    skid_data_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0)
    ) u_skid (
        .Clock (Clock),
        .Reset (Reset),
        .load  (load_skid),
        .d     (in_data),
        .q     (skid_q)
    );

    assign occupancy = state_to_occ(state);

`ifdef PIPE_SKID_TRISTATE_EN
    assign out_data = cs ? {WIDTH{1'bz}} : main_q;
`else
    assign out_data = main_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: occupancy model plus FIFO scoreboard.
// Define PIPE_SKID_TRISTATE_EN to also exercise the cs tristate path.
module tb_pipe_stage_skid_reg;

    localparam int          W     = 32;
    localparam logic [31:0] RST_V = 32'h5A5A_0000;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Tick = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [1:0]    occupancy;
`ifdef PIPE_SKID_TRISTATE_EN
    logic          cs = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [W-1:0] sb_q[$];
    int           m_occ  = 0;
    logic [W-1:0] m_main = RST_V;

    always #5 Clock = ~Clock;

    pipe_stage_skid_reg #(
        .WIDTH       (W),
        .RESET_VALUE (RST_V)
    ) dut (
`ifdef PIPE_SKID_TRISTATE_EN
        .cs        (cs),
`endif
        .Clock     (Clock),
        .Reset     (Reset),
        .Tick      (Tick),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_occ"},   W'(occupancy), W'(m_occ));
        check_val({tag, "_ovld"},  W'(out_valid), W'(m_occ != 0));
        check_val({tag, "_irdy"},  W'(in_ready),  W'(m_occ != 2));
        check_val({tag, "_odata"}, out_data,      m_main);
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_occ  = 0;
        m_main = RST_V;
    endtask

    // Called just after a falling edge: drive inputs, predict the next edge, then check.
    task automatic cyc(input string tag, input logic iv, input logic [W-1:0] d,
                       input logic ordy, input logic tk, input logic fl);
        logic m_push;
        logic m_pop;
        logic [W-1:0] exp_pop;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        Tick      = tk;
        flush     = fl;
        m_push = iv && (m_occ != 2) && tk;
        m_pop  = (m_occ != 0) && ordy && tk;
        #1;
        if (m_pop) begin
            exp_pop = sb_q[0];
            check_val({tag, "_pop"}, out_data, exp_pop);
        end
        if (fl) begin
            sb_q.delete();
            m_occ = 0;
        end else begin
            if (m_pop) void'(sb_q.pop_front());
            if (m_push) sb_q.push_back(d);
            m_occ = sb_q.size();
        end
        if (sb_q.size() > 0) m_main = sb_q[0];
        @(posedge Clock);
        @(negedge Clock);
        check_state(tag);
    endtask

    initial begin
        // Reset then idle
        @(negedge Clock);
        check_state("rst_hold");
        Reset = 1'b0;
        @(negedge Clock);
        cyc("idle", 1'b0, '0, 1'b0, 1'b1, 1'b0);
        cyc("idle", 1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Back-to-back stream at full throughput
        cyc("strm", 1'b1, 32'h11, 1'b1, 1'b1, 1'b0);
        check_val("strm_lat", out_data, 32'h11);
        cyc("strm", 1'b1, 32'h22, 1'b1, 1'b1, 1'b0);
        cyc("strm", 1'b1, 32'h33, 1'b1, 1'b1, 1'b0);
        check_val("strm_nobubble", W'(out_valid), W'(1));
        cyc("strm", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        cyc("strm", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_val("empty_last", out_data, 32'h33);

        // Fill to FULL under backpressure, then drain in order
        cyc("bp", 1'b1, 32'hA1, 1'b0, 1'b1, 1'b0);
        cyc("bp", 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0);
        check_val("bp_full_occ", W'(occupancy), W'(2));
        cyc("bp", 1'b1, 32'hA3, 1'b0, 1'b1, 1'b0);
        check_val("bp_hold", out_data, 32'hA1);
        cyc("bp", 1'b1, 32'hA3, 1'b1, 1'b1, 1'b0);
        cyc("bp", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        cyc("bp", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        cyc("bp", 1'b0, '0, 1'b1, 1'b1, 1'b0);

        // Flush while FULL with a concurrent push
        cyc("fl", 1'b1, 32'hC1, 1'b0, 1'b1, 1'b0);
        cyc("fl", 1'b1, 32'hC2, 1'b0, 1'b1, 1'b0);
        cyc("fl", 1'b1, 32'hB0, 1'b0, 1'b1, 1'b1);
        check_val("fl_occ", W'(occupancy), W'(0));
        cyc("fl", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        cyc("fl", 1'b0, '0, 1'b1, 1'b1, 1'b0);
        check_val("fl_no_b0", W'(out_data == 32'hB0), W'(0));
        // Flush also acts with Tick low
        cyc("fltk", 1'b1, 32'hD1, 1'b0, 1'b1, 1'b0);
        cyc("fltk", 1'b1, 32'hD2, 1'b0, 1'b0, 1'b1);

        // Tick low freezes everything, then resumes
        cyc("tk", 1'b1, 32'hE1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc("tk0", 1'b1, 32'hE2, 1'b1, 1'b0, 1'b0);
        check_val("tk0_data", out_data, 32'hE1);
        cyc("tk1", 1'b1, 32'hE2, 1'b1, 1'b1, 1'b0);
        cyc("tk1", 1'b0, '0, 1'b1, 1'b1, 1'b0);

`ifdef PIPE_SKID_TRISTATE_EN
        cyc("cs", 1'b1, 32'hF1, 1'b0, 1'b1, 1'b0);
        cs = 1'b1;
        #1;
        check_val("cs_z", out_data, {W{1'bz}});
        check_val("cs_vld", W'(out_valid), W'(1));
        cs = 1'b0;
        #1;
        check_val("cs_restore", out_data, 32'hF1);
        cyc("cs", 1'b0, '0, 1'b1, 1'b1, 1'b0);
`endif

        // Reset in the middle of a transfer
        cyc("mrst", 1'b1, 32'h77, 1'b0, 1'b1, 1'b0);
        cyc("mrst", 1'b1, 32'h78, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        Reset = 1'b1;
        #1;
        model_reset();
        check_state("mrst_now");
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        check_state("mrst_after");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rnd", 1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 30) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1);
    end

endmodule
